// File: rtl/logic_op_pkg.sv
// ============================================================================
// Module      : logic_op_pkg
// Description : Op codes and FSM state encoding shared by the logic-op arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package logic_op_pkg;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_NAND = 2'b11;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_EXEC = 2'd1;
    localparam state_t ST_HOLD = 2'd2;

endpackage

`default_nettype wire

// File: rtl/logic_op_arbiter_rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker; first request at or after
//               the pointer, wrapping modulo NUM_REQ.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [ID_W-1:0]    o_idx,
    output logic               o_any_req
);

    logic w_found;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            logic [ID_W:0]   sum;
            logic [ID_W-1:0] pos;
            // One spare bit so ptr+k cannot overflow before the wrap
            sum = {1'b0, i_ptr} + (ID_W+1)'(k);
            if (sum >= (ID_W+1)'(NUM_REQ)) begin
                sum = sum - (ID_W+1)'(NUM_REQ);
            end
            pos = sum[ID_W-1:0];
            if (!w_found && i_req[pos]) begin
                o_gnt[pos] = 1'b1;
                o_idx      = pos;
                w_found    = 1'b1;
            end
        end
    end

    assign o_any_req = |i_req;

endmodule

`default_nettype wire

// File: rtl/logic_op_arbiter.sv
// ============================================================================
// Module      : logic_op_arbiter
// Description : Round-robin shared bitwise logic unit with registered result
//               held under a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module logic_op_arbiter
    import logic_op_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NUM_REQ-1:0]       REQ_VALID,
    input  logic [2*NUM_REQ-1:0]     REQ_OP,
    input  logic [WIDTH*NUM_REQ-1:0] REQ_A,
    input  logic [WIDTH*NUM_REQ-1:0] REQ_B,
    output logic [NUM_REQ-1:0]       GNT,
    output logic [WIDTH-1:0]         OUT,
    output logic [ID_W-1:0]          OUT_ID,
    output logic                     OUT_VALID,
    input  logic                     OUT_READY,
    output logic                     BUSY
);

    state_t r_state;
    state_t w_state_nxt;

    logic [ID_W-1:0]    r_ptr;
    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [ID_W-1:0]    r_id;
    logic [WIDTH-1:0]   r_out;
    logic [ID_W-1:0]    r_out_id;
    logic               r_out_valid;

    logic [NUM_REQ-1:0] w_pick_gnt;
    logic [ID_W-1:0]    w_pick_idx;
    logic               w_pick_any;
    logic [ID_W-1:0]    w_ptr_nxt;
    logic [WIDTH-1:0]   w_result;
    wire  [WIDTH-1:0]   w_and;
    wire  [WIDTH-1:0]   w_or;

    logic [1:0]         w_op_arr [NUM_REQ];
    logic [WIDTH-1:0]   w_a_arr  [NUM_REQ];
    logic [WIDTH-1:0]   w_b_arr  [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
        assign w_op_arr[gi] = REQ_OP[2*gi +: 2];
        assign w_a_arr[gi]  = REQ_A[WIDTH*gi +: WIDTH];
        assign w_b_arr[gi]  = REQ_B[WIDTH*gi +: WIDTH];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .i_req     (REQ_VALID),
        .i_ptr     (r_ptr),
        .o_gnt     (w_pick_gnt),
        .o_idx     (w_pick_idx),
        .o_any_req (w_pick_any)
    );

    assign w_ptr_nxt = (w_pick_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_pick_idx + 1'b1;

    // AND/OR paths as per-bit gate cells; XOR and NAND derive from plain logic
    for (genvar gb = 0; gb < WIDTH; gb++) begin : g_bit
        and u_and (w_and[gb], r_a[gb], r_b[gb]);
        or  u_or  (w_or[gb],  r_a[gb], r_b[gb]);
    end

    always_comb begin
        w_result = w_and;
        case (r_op)
            OP_AND:  w_result = w_and;
            OP_OR:   w_result = w_or;
            OP_XOR:  w_result = r_a ^ r_b;
            OP_NAND: w_result = ~w_and;
            default: w_result = w_and;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_pick_any) w_state_nxt = ST_EXEC;
            ST_EXEC: w_state_nxt = ST_HOLD;
            ST_HOLD: if (OUT_READY) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        GNT  = '0;
        BUSY = (r_state != ST_IDLE);
        if (r_state == ST_IDLE && !RST) begin
            GNT = w_pick_gnt;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ptr       <= '0;
            r_op        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_id        <= '0;
            r_out       <= '0;
            r_out_id    <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_any) begin
                        r_op  <= w_op_arr[w_pick_idx];
                        r_a   <= w_a_arr[w_pick_idx];
                        r_b   <= w_b_arr[w_pick_idx];
                        r_id  <= w_pick_idx;
                        r_ptr <= w_ptr_nxt;
                    end
                end
                ST_EXEC: begin
                    r_out       <= w_result;
                    r_out_id    <= r_id;
                    r_out_valid <= 1'b1;
                end
                ST_HOLD: begin
                    if (OUT_READY) r_out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign OUT       = r_out;
    assign OUT_ID    = r_out_id;
    assign OUT_VALID = r_out_valid;

endmodule

`default_nettype wire
